// File: rtl/csync_pkg.sv
// rtl/csync_pkg.sv - shared timing helpers, pulse classes and default sync timing constants
package csync_pkg;

    typedef enum logic {
        PULSE_SHORT = 1'b0,
        PULSE_BROAD = 1'b1
    } pulse_class_t;

    // Nominal composite-sync timings in nanoseconds
    localparam int unsigned HSYNC_NS     = 4700;
    localparam int unsigned EQ_NS        = 2350;
    localparam int unsigned BROAD_NS     = 27300;
    localparam int unsigned PAL_LINE_NS  = 64000;
    localparam int unsigned NTSC_LINE_NS = 63500;

    function automatic int unsigned us_to_cyc(input longint unsigned clk_freq,
                                              input longint unsigned us);
        longint unsigned cyc;
        cyc = clk_freq * us / 64'd1_000_000;
        return cyc[31:0];
    endfunction

    function automatic int unsigned ns_to_cyc(input longint unsigned clk_freq,
                                              input longint unsigned ns);
        longint unsigned cyc;
        cyc = clk_freq * ns / 64'd1_000_000_000;
        return cyc[31:0];
    endfunction

endpackage

// File: rtl/csync_deglitch.sv
// rtl/csync_deglitch.sv - csync synchroniser, glitch filter and filtered edge strobes
// Ports:
//   clk_in   system clock
//   rst_n    synchronous active-low reset
//   csync_in raw asynchronous composite sync
//   level    filtered sync level (idle high)
//   fall     one-cycle strobe on a filtered falling edge
//   rise     one-cycle strobe on a filtered rising edge
module csync_deglitch #(
    parameter int unsigned GLITCH_CYC = 8
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic csync_in,
    output logic level,
    output logic fall,
    output logic rise
);

    localparam int CW = $clog2(GLITCH_CYC + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= csync_in;
            sync2 <= sync1;
            fall  <= 1'b0;
            rise  <= 1'b0;
            // Any sample agreeing with the current level restarts the run
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(GLITCH_CYC - 1)) begin
                cnt   <= '0;
                level <= sync2;
                fall  <= level;
                rise  <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/csync_field_analyzer.sv
// rtl/csync_field_analyzer.sv - composite sync line/field counter with PAL/NTSC and loss detection
// Ports:
//   clk_in           system clock
//   rst_n            synchronous active-low reset
//   csync_in         raw composite sync, active-low pulses
//   line_count       lines since the last field boundary (saturating)
//   line_count_valid set from the first field boundary after reset/loss
//   frame_lines      line_count latched at the most recent boundary
//   frame_valid      frame_lines holds a complete field
//   field_strobe     one-cycle pulse per field boundary
//   std_pal          1 = PAL, 0 = NTSC (valid with frame_valid)
//   sync_lost        no filtered falling edge for LOSS_US
module csync_field_analyzer
    import csync_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 100_000_000,
    parameter int unsigned LINE_W        = 10,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned GLITCH_CYC    = 8,
    parameter int unsigned BROAD_MIN_US  = 20,
    parameter int unsigned LINE_MIN_US   = 48,
    parameter int unsigned BROAD_RUN     = 3,
    parameter int unsigned LOSS_US       = 200,
    parameter int unsigned PAL_MIN_LINES = 290
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              csync_in,
    output logic [LINE_W-1:0] line_count,
    output logic              line_count_valid,
    output logic [LINE_W-1:0] frame_lines,
    output logic              frame_valid,
    output logic              field_strobe,
    output logic              std_pal,
    output logic              sync_lost
);

    localparam logic [CNT_W-1:0]  BROAD_MIN_C = CNT_W'(us_to_cyc(CLK_FREQ, BROAD_MIN_US));
    localparam logic [CNT_W-1:0]  LINE_MIN_C  = CNT_W'(us_to_cyc(CLK_FREQ, LINE_MIN_US));
    localparam int unsigned       LOSS_CYC    = us_to_cyc(CLK_FREQ, LOSS_US);
    localparam int                LOSS_W      = $clog2(LOSS_CYC + 1);
    localparam int                RUN_W       = $clog2(BROAD_RUN + 1);
    localparam logic [LINE_W-1:0] PAL_MIN_C   = LINE_W'(PAL_MIN_LINES);

    logic              level;
    logic              fall;
    logic              rise;
    logic [CNT_W-1:0]  width;
    logic [CNT_W-1:0]  period;
    logic [LOSS_W-1:0] loss_cnt;
    logic [RUN_W-1:0]  broad_cnt;
    logic              armed;
    logic              gate_open;

    pulse_class_t pclass;
    logic         line_evt;
    logic         boundary_evt;
    logic         loss_evt;

    csync_deglitch #(.GLITCH_CYC(GLITCH_CYC)) u_deglitch (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .csync_in (csync_in),
        .level    (level),
        .fall     (fall),
        .rise     (rise)
    );

    always_comb begin
        pclass       = (width >= BROAD_MIN_C) ? PULSE_BROAD : PULSE_SHORT;
        // Half-line pulses arrive before the period timer reaches LINE_MIN
        line_evt     = rise && (pclass == PULSE_SHORT) && (gate_open || (period >= LINE_MIN_C));
        // Only the step into BROAD_RUN fires; longer broad runs saturate silently
        boundary_evt = rise && (pclass == PULSE_BROAD) && (broad_cnt == RUN_W'(BROAD_RUN - 1));
        loss_evt     = !sync_lost && !fall && (loss_cnt == LOSS_W'(LOSS_CYC - 1));
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            line_count       <= '0;
            line_count_valid <= 1'b0;
            frame_lines      <= '0;
            frame_valid      <= 1'b0;
            field_strobe     <= 1'b0;
            std_pal          <= 1'b0;
            sync_lost        <= 1'b0;
            width            <= '0;
            period           <= '0;
            loss_cnt         <= '0;
            broad_cnt        <= '0;
            armed            <= 1'b0;
            gate_open        <= 1'b1;
        end else begin
            field_strobe <= 1'b0;

            if (fall)
                width <= '0;
            else if (!level && (width != '1))
                width <= width + 1'b1;

            if (line_evt)
                period <= '0;
            else if (period != '1)
                period <= period + 1'b1;

            if (fall) begin
                loss_cnt  <= '0;
                sync_lost <= 1'b0;
            end else if (loss_evt) begin
                sync_lost <= 1'b1;
            end else if (!sync_lost) begin
                loss_cnt <= loss_cnt + 1'b1;
            end

            if (loss_evt) begin
                line_count       <= '0;
                line_count_valid <= 1'b0;
                frame_valid      <= 1'b0;
                armed            <= 1'b0;
                broad_cnt        <= '0;
                gate_open        <= 1'b1;
            end else if (rise) begin
                if (pclass == PULSE_SHORT) begin
                    broad_cnt <= '0;
                    if (line_evt) begin
                        if (line_count != '1)
                            line_count <= line_count + 1'b1;
                        gate_open <= 1'b0;
                    end
                end else begin
                    if (broad_cnt != RUN_W'(BROAD_RUN))
                        broad_cnt <= broad_cnt + 1'b1;
                    if (boundary_evt) begin
                        field_strobe     <= 1'b1;
                        line_count_valid <= 1'b1;
                        line_count       <= '0;
                        gate_open        <= 1'b1;
                        armed            <= 1'b1;
                        // The first boundary only marks where a full field starts
                        if (armed) begin
                            frame_lines <= line_count;
                            frame_valid <= 1'b1;
                            std_pal     <= (line_count >= PAL_MIN_C);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/csync_field_analyzer.md
Name: csync_field_analyzer

Overview:
Parametrised successor to the CSYNC line counter.
- Conditions composite sync: 2-FF synchroniser plus glitch filter.
- Classifies each low pulse as short (hsync/equalising) or broad (vsync serration).
- Rejects half-line pulses, finds field boundaries, latches lines-per-field and classifies PAL/NTSC.
- Includes loss-of-sync supervision.
- Sits between the CSYNC input pin and the video-standard/overlay logic.

Parameters:
CLK_FREQ, 100_000_000, clk_in frequency in Hz; all *_US values convert to cycles as CLK_FREQ*us/1_000_000.
LINE_W, 10, width of line_count and frame_lines.
CNT_W, 16, width of the pulse-width and period timers; timers saturate at all-ones.
GLITCH_CYC, 8, consecutive equal samples required before the filtered level changes.
BROAD_MIN_US, 20, low-pulse width at or above which a pulse is broad.
LINE_MIN_US, 48, minimum spacing between counted lines; rejects 32 us half-line pulses.
BROAD_RUN, 3, consecutive broad pulses that declare a field boundary.
LOSS_US, 200, time without a filtered falling edge before sync is declared lost.
PAL_MIN_LINES, 290, frame_lines at or above this value means PAL; below it means NTSC.

Ports:
clk_in  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
csync_in  in  1  raw composite sync; asynchronous; active-low pulses
line_count  out  LINE_W  lines counted since the last field boundary; saturates at all-ones
line_count_valid  out  1  set at the first field boundary after reset or sync loss
frame_lines  out  LINE_W  line_count value latched at the most recent field boundary
frame_valid  out  1  frame_lines holds a complete field; set at the second boundary
field_strobe  out  1  one-cycle pulse at each field boundary
std_pal  out  1  1 = PAL, 0 = NTSC; meaningful only while frame_valid is 1
sync_lost  out  1  no falling edge seen for LOSS_US

Behaviour:
- Reset: when rst_n=0 at a clk_in edge, the following are cleared on that edge:
  - all outputs to 0;
  - filtered level to 1;
  - timers, broad-run counter and armed flag to 0;
  - line gate to open.
  Reset mid-field discards any partial field.
- Conditioning:
  - csync_in passes through 2 FFs, then the filter.
  - The filtered level toggles only after GLITCH_CYC consecutive synchronised samples differ from it.
  - Edge strobes are derived from the filtered level.
  - Latency from csync_in to edge strobe: 2 + GLITCH_CYC cycles.
- Width timer:
  - Cleared on a filtered falling edge.
  - Increments each cycle while the filtered level is low.
- Classification happens on a filtered rising edge:
  - broad if width >= BROAD_MIN cycles;
  - short otherwise.
- Short pulse:
  - Broad-run counter is cleared.
  - The pulse counts as a line if the gate is open or the period timer is >= LINE_MIN cycles.
  - Period timer: cleared on each counted line, increments each cycle, saturates.
  - A counted line increments line_count (saturating), clears the period timer and closes the gate.
  - A short pulse that is not counted is ignored.
- Broad pulse:
  - Broad-run counter increments, saturating at BROAD_RUN.
  - The boundary fires only on the transition to BROAD_RUN; further broad pulses in the same run (PAL has 5) do nothing.
- Field boundary actions, all in one cycle:
  - field_strobe=1;
  - line_count_valid=1;
  - line_count<=0;
  - gate opens.
  - First boundary since reset/loss: sets armed only; frame_lines stays unchanged.
  - Later boundaries: frame_lines<=line_count, frame_valid=1, std_pal<=(line_count>=PAL_MIN_LINES).
- Same-cycle events: boundary reset and increment never coincide, because classification events are mutually exclusive.
- Loss of sync: loss timer counts cycles since the last filtered falling edge. At LOSS_US:
  - sync_lost=1;
  - line_count=0; line_count_valid=0; frame_valid=0;
  - armed=0; broad-run counter=0; gate opens.
  - frame_lines and std_pal hold their last values.
  - The next filtered falling edge clears sync_lost; acquisition then restarts from the unarmed state.
- Outputs are registered; the width and period timers never wrap.

Decomposition:
Package csync_pkg:
- us_to_cyc function;
- pulse-class enum (PULSE_SHORT, PULSE_BROAD);
- default timing constants (hsync 4.7 us, equalising 2.35 us, broad 27.3 us, line 64/63.5 us) shared with the benches.

Sub-module csync_deglitch: synchroniser, GLITCH_CYC filter, fall/rise strobes.

Test Plan:
- Reset, then 5 broad (27 us low / 32 us period), 312 hsync (4.7 us / 64 us), 5 broad, 312 hsync, 5 broad -> field_strobe three times; frame_valid=1, frame_lines=312, std_pal=1.
- Same sequence with 262 lines and 63.5 us period -> frame_lines=262, std_pal=0; line_count_valid=1 from the first boundary.
- Mid-field hsync at t=0, 2.35 us equalising at t=32 us, hsync at t=64 us -> line_count increases by exactly 2.
- 40 ns low glitch (4 cycles) on idle-high csync -> no edge, line_count unchanged; an 8-cycle low pulse is accepted.
- Hold csync high 250 us after lock -> sync_lost=1 at 200 us + latency; valid flags 0; frame_lines held. Resume -> sync_lost clears on the first falling edge; frame_valid returns only after two boundaries.
- rst_n=0 for one cycle mid-field at line_count=100 -> all outputs 0 on the next edge; a subsequent boundary sets only line_count_valid.
